// File: rtl/dut_stream_pkg.sv
// Shared widths, beat layout and packer state encoding for the sample-to-stream packer.
package dut_stream_pkg;

   localparam int unsigned SAMPLE_W = 16;
   localparam int unsigned DATA_W   = 2 * SAMPLE_W;
   localparam int unsigned KEEP_W   = SAMPLE_W / 4;
   localparam int unsigned CNT_W    = 16;

   typedef struct packed {
      logic              tlast;
      logic [KEEP_W-1:0] tkeep;
      logic [DATA_W-1:0] tdata;
   } beat_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_FLUSH_HOLD,
      ST_FLUSH_PART
   } pack_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; the head entry is presented from a registered copy of memory.
module sync_fifo_fwft #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      level_q, level_d, resident;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             dout_v_q, dout_v_d;
   logic             wr_fire, rd_fire;

   // An entry becomes visible one cycle after it lands in memory, so the head is
   // only refreshed from entries that were already resident before this cycle.
   always_comb begin
      rd_fire  = rd_en && dout_v_q;
      wr_fire  = wr_en && ((level_q != FULL_LVL) || rd_fire);
      rptr_d   = rd_fire ? rptr_q + AW'(1) : rptr_q;
      wptr_d   = wr_fire ? wptr_q + AW'(1) : wptr_q;
      resident = rd_fire ? level_q - (AW+1)'(1) : level_q;
      level_d  = wr_fire ? resident + (AW+1)'(1) : resident;
      dout_v_d = (resident != '0);
      dout_d   = dout_v_d ? mem_q[rptr_d] : dout_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         level_q  <= '0;
         dout_q   <= '0;
         dout_v_q <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         level_q  <= level_d;
         dout_q   <= dout_d;
         dout_v_q <= dout_v_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wptr_q] <= wr_data;
   end

   assign rd_data = dout_q;
   assign full    = (level_q == FULL_LVL);
   assign empty   = !dout_v_q;
   assign level   = level_q;

endmodule

// File: rtl/dut_stream_packer.sv
// Packs pairs of DUT samples into 32-bit AXI-Stream beats, frames fixed-length packets and flushes on capture stop.
module dut_stream_packer
   import dut_stream_pkg::*;
#(
   parameter int unsigned SAMPLE_W   = dut_stream_pkg::SAMPLE_W,
   parameter int unsigned PKT_BEATS  = 256,
   parameter int unsigned FIFO_DEPTH = 512
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic [SAMPLE_W-1:0]           sample_in,
   input  logic                          sample_valid,
   output logic [2*SAMPLE_W-1:0]         m_axis_tdata,
   output logic [SAMPLE_W/4-1:0]         m_axis_tkeep,
   output logic                          m_axis_tlast,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          overflow,
   output logic [31:0]                   drop_cnt,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int unsigned DW        = 2 * SAMPLE_W;
   localparam int unsigned KW        = SAMPLE_W / 4;
   localparam int unsigned BW        = 1 + KW + DW;
   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(PKT_BEATS - 1);

   pack_state_e       state_q, state_d;
   logic              lane_q, lane_d;
   logic [SAMPLE_W-1:0] half_q, half_d;
   logic              hold_v_q, hold_v_d;
   logic [DW-1:0]     hold_q, hold_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              overflow_q, overflow_d;
   logic [31:0]       drop_cnt_q, drop_cnt_d;

   logic              accept, push_req, push_ok, push_last, flush_done, pop;
   logic [DW-1:0]     push_data;
   logic [KW-1:0]     push_keep;
   logic              fifo_full, fifo_empty;
   logic [BW-1:0]     fifo_rd_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         lane_q     <= 1'b0;
         half_q     <= '0;
         hold_v_q   <= 1'b0;
         hold_q     <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lane_q     <= lane_d;
         half_q     <= half_d;
         hold_v_q   <= hold_v_d;
         hold_q     <= hold_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:       if (en) state_d = ST_RUN;
         ST_RUN: begin
            if (!en) begin
               if (hold_v_q)    state_d = ST_FLUSH_HOLD;
               else if (lane_q) state_d = ST_FLUSH_PART;
               else             state_d = ST_IDLE;
            end
         end
         ST_FLUSH_HOLD: state_d = lane_q ? ST_FLUSH_PART : ST_IDLE;
         ST_FLUSH_PART: state_d = ST_IDLE;
         default:       state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      lane_d     = lane_q;
      half_d     = half_q;
      hold_v_d   = hold_v_q;
      hold_d     = hold_q;
      cnt_d      = cnt_q;
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
      push_req   = 1'b0;
      push_data  = hold_q;
      push_keep  = '1;
      push_last  = (cnt_q == LAST_BEAT);
      accept     = en && sample_valid && ((state_q == ST_IDLE) || (state_q == ST_RUN));

      // A completed word displaces the held one, which is what actually gets pushed.
      if (accept) begin
         if (!lane_q) begin
            half_d = sample_in;
            lane_d = 1'b1;
         end else begin
            hold_d   = {sample_in, half_q};
            hold_v_d = 1'b1;
            lane_d   = 1'b0;
            push_req = hold_v_q;
         end
      end

      case (state_q)
         ST_FLUSH_HOLD: begin
            push_req  = 1'b1;
            push_last = !lane_q;
            hold_v_d  = 1'b0;
         end
         ST_FLUSH_PART: begin
            push_req  = 1'b1;
            push_data = {{SAMPLE_W{1'b0}}, half_q};
            push_keep = {{(KW - KW/2){1'b0}}, {(KW/2){1'b1}}};
            push_last = 1'b1;
         end
         default: ;
      endcase

      push_ok = push_req && (!fifo_full || pop);
      if (push_ok) begin
         cnt_d = (cnt_q == LAST_BEAT) ? '0 : cnt_q + CNT_W'(1);
      end else if (push_req) begin
         overflow_d = 1'b1;
         if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
      end

      flush_done = (state_q != ST_IDLE) && (state_d == ST_IDLE);
      if (flush_done) begin
         lane_d   = 1'b0;
         hold_v_d = 1'b0;
         cnt_d    = '0;
      end
   end

   sync_fifo_fwft #(
      .WIDTH (BW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (push_ok),
      .wr_data ({push_last, push_keep, push_data}),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   assign m_axis_tvalid = !fifo_empty;
   assign pop           = m_axis_tvalid && m_axis_tready;
   assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = fifo_rd_data;
   assign overflow      = overflow_q;
   assign drop_cnt      = drop_cnt_q;

endmodule

// File: tb/tb_dut_stream_packer.sv
// Directed and randomised checks of dut_stream_packer against a scoreboard of expected beats.
module tb_dut_stream_packer;

   localparam int unsigned PKT = 4;

   logic        clk = 1'b0, rst = 1'b0, en = 1'b0, en2 = 1'b0;
   logic        sample_valid = 1'b0, tready = 1'b0, s_tready = 1'b0;
   logic [15:0] sample_in = '0;

   logic [31:0] tdata, s_tdata, drop_cnt, s_drop_cnt;
   logic [3:0]  tkeep, s_tkeep, fifo_level, s_fifo_level;
   logic        tlast, tvalid, overflow, s_tlast, s_tvalid, s_overflow;

   int checks = 0, failures = 0;
   logic [36:0] exp_q[$];

   bit          m_lane = 1'b0, m_hold_v = 1'b0;
   logic [15:0] m_half = '0;
   logic [31:0] m_hold = '0;
   int          m_cnt = 0, m_space = -1;

   always #5 clk = ~clk;

   dut_stream_packer #(.SAMPLE_W(16), .PKT_BEATS(4), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .en(en), .sample_in(sample_in), .sample_valid(sample_valid),
      .m_axis_tdata(tdata), .m_axis_tkeep(tkeep), .m_axis_tlast(tlast), .m_axis_tvalid(tvalid),
      .m_axis_tready(tready), .overflow(overflow), .drop_cnt(drop_cnt), .fifo_level(fifo_level)
   );

   dut_stream_packer #(.SAMPLE_W(16), .PKT_BEATS(2), .FIFO_DEPTH(8)) u_sat (
      .clk(clk), .rst(rst), .en(en2), .sample_in(sample_in), .sample_valid(sample_valid),
      .m_axis_tdata(s_tdata), .m_axis_tkeep(s_tkeep), .m_axis_tlast(s_tlast), .m_axis_tvalid(s_tvalid),
      .m_axis_tready(s_tready), .overflow(s_overflow), .drop_cnt(s_drop_cnt), .fifo_level(s_fifo_level)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      sample_valid = 1'b0;
      repeat (n) step();
   endtask

   // last_mode: 0/1 forced tlast, 2 = tlast from packet position
   task automatic model_push(input logic [31:0] d, input logic [3:0] k, input int last_mode);
      logic l;
      if (m_space == 0) return;
      l = (last_mode == 2) ? (m_cnt == PKT - 1) : (last_mode == 1);
      exp_q.push_back({l, k, d});
      m_cnt = (m_cnt == PKT - 1) ? 0 : m_cnt + 1;
      if (m_space > 0) m_space--;
   endtask

   task automatic model_accept(input logic [15:0] s);
      if (!m_lane) begin
         m_half = s;
         m_lane = 1'b1;
      end else begin
         if (m_hold_v) model_push(m_hold, 4'hF, 2);
         m_hold   = {s, m_half};
         m_hold_v = 1'b1;
         m_lane   = 1'b0;
      end
   endtask

   task automatic model_flush();
      if (m_lane) begin
         if (m_hold_v) model_push(m_hold, 4'hF, 0);
         model_push({16'h0000, m_half}, 4'h3, 1);
      end else if (m_hold_v) begin
         model_push(m_hold, 4'hF, 1);
      end
      m_lane = 1'b0; m_hold_v = 1'b0; m_cnt = 0;
   endtask

   task automatic model_reset();
      m_lane = 1'b0; m_hold_v = 1'b0; m_cnt = 0; m_space = -1;
      exp_q.delete();
   endtask

   task automatic send(input logic [15:0] s);
      sample_in    = s;
      sample_valid = 1'b1;
      if (en) model_accept(s);
      step();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, tvalid, 0);
      chk({tag, "_tdata"}, tdata, 0);
      chk({tag, "_tkeep"}, tkeep, 0);
      chk({tag, "_tlast"}, tlast, 0);
      chk({tag, "_overflow"}, overflow, 0);
      chk({tag, "_drop_cnt"}, drop_cnt, 0);
      chk({tag, "_fifo_level"}, fifo_level, 0);
   endtask

   logic [36:0] cur_beat, prev_beat, exp_beat;
   bit          prev_stall = 1'b0;

   always @(negedge clk) begin
      cur_beat = {tlast, tkeep, tdata};
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) chk("stall_stable", cur_beat, prev_beat);
         if (tvalid && tready) begin
            chk("beat_pending", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               exp_beat = exp_q.pop_front();
               chk("beat", cur_beat, exp_beat);
            end
         end
         prev_stall = tvalid && !tready;
         prev_beat  = cur_beat;
      end
   end

   initial begin
      int n;
      #2 rst = 1'b1;
      #2 check_reset_outputs("reset");
      repeat (2) step();
      rst = 1'b0;
      step();

      // packing and packet framing
      en = 1'b1; tready = 1'b1;
      for (int i = 1; i <= 16; i++) send(16'(i));
      en = 1'b0; model_flush();
      idle(12);
      chk("t1_drained", exp_q.size(), 0);
      chk("t1_tvalid_idle", tvalid, 0);

      // flush with held word and half word pending
      en = 1'b1;
      send(16'h000A); send(16'h000B); send(16'h000C);
      en = 1'b0; model_flush();
      idle(10);
      chk("t2_drained", exp_q.size(), 0);
      chk("t2_tvalid_idle", tvalid, 0);

      // overflow under backpressure
      tready = 1'b0; m_space = 8; en = 1'b1;
      for (int i = 0; i < 40; i++) send(16'(16'h0100 + i));
      idle(3);
      chk("t3_level_full", fifo_level, 8);
      chk("t3_drop_cnt", drop_cnt, 11);
      chk("t3_overflow", overflow, 1);
      m_space = -1; tready = 1'b1;
      idle(12);
      chk("t3_drained", exp_q.size(), 0);
      chk("t3_tvalid_idle", tvalid, 0);
      en = 1'b0; model_flush();
      idle(8);
      chk("t3_flush_drained", exp_q.size(), 0);

      // random backpressure and sample gaps
      en = 1'b1; n = 0;
      for (int cyc = 0; (n < 1000) && (cyc < 20000); cyc++) begin
         tready = ($urandom_range(0, 9) < 6);
         if ($urandom_range(0, 1) == 1) begin
            send(16'($urandom));
            n++;
         end else begin
            idle(1);
         end
      end
      chk("t4_samples_sent", n, 1000);
      tready = 1'b1; en = 1'b0; model_flush();
      idle(30);
      chk("t4_drained", exp_q.size(), 0);
      chk("t4_no_new_drops", drop_cnt, 11);

      // asynchronous reset mid-packet
      tready = 1'b0; en = 1'b1;
      for (int i = 1; i <= 5; i++) send(16'(16'h0200 + i));
      idle(3);
      chk("t5_pre_tvalid", tvalid, 1);
      chk("t5_pre_level", fifo_level, 1);
      #2 rst = 1'b1;
      en = 1'b0;
      #1 check_reset_outputs("t5_async");
      model_reset();
      step();
      rst = 1'b0;
      step();
      en = 1'b1; tready = 1'b1;
      for (int i = 1; i <= 10; i++) send(16'(16'h0300 + i));
      en = 1'b0; model_flush();
      idle(12);
      chk("t5_restart_drained", exp_q.size(), 0);

      // drop counter saturation on the PKT_BEATS=2 instance
      en2 = 1'b1;
      for (int i = 0; i < 40; i++) send(16'(i));
      idle(2);
      chk("t6_drop_cnt", s_drop_cnt, 11);
      chk("t6_overflow", s_overflow, 1);
      force u_sat.drop_cnt_q = 32'hFFFF_FFFE;
      step();
      release u_sat.drop_cnt_q;
      step();
      chk("t6_forced", s_drop_cnt, 32'hFFFF_FFFE);
      for (int i = 0; i < 10; i++) send(16'(i));
      idle(2);
      chk("t6_saturated", s_drop_cnt, 32'hFFFF_FFFF);
      for (int i = 0; i < 8; i++) send(16'(i));
      idle(2);
      chk("t6_no_wrap", s_drop_cnt, 32'hFFFF_FFFF);
      chk("t6_level", s_fifo_level, 8);
      en2 = 1'b0;
      idle(4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
